// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction handshake between fetch unit and control unit
//
// Purpose: carries the fetched instruction word (valid/ready) toward the control
// unit and the branch redirect (pc_load) back to the fetch unit.
// Signals:
//   ir_opcode/ir_operand1/ir_operand2  fetch -> control  instruction fields
//   ir_valid                           fetch -> control  fields valid
//   ir_ready                           control -> fetch  instruction accepted
//   pc_load/pc_load_addr               control -> fetch  redirect strobe and target
// Modports: master = fetch unit, slave = control unit.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] ir_opcode;
  logic [DATA_W-1:0] ir_operand1;
  logic [DATA_W-1:0] ir_operand2;
  logic              ir_valid;
  logic              ir_ready;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_addr;

  modport master (
    output ir_opcode, ir_operand1, ir_operand2, ir_valid,
    input  ir_ready, pc_load, pc_load_addr
  );

  modport slave (
    input  ir_opcode, ir_operand1, ir_operand2, ir_valid,
    output ir_ready, pc_load, pc_load_addr
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter owner and 3-byte instruction fetcher
//
// Purpose: reads opcode/operand1/operand2 from program RAM one byte per cycle
// starting at PC and presents them as a valid/ready word; pc_load redirects.
// Optional feature macro: FETCH_HALT_DETECT_EN (accepting opcode 8'hFF halts).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  fetch enable (0 stops starting new fetches)
//   mem_addr/mem_rd_en  RAM read address and strobe (data returns next cycle)
//   mem_rdata           RAM read data
//   pc_out              registered PC of the instruction being fetched or held
//   halted              halt opcode accepted (tied 0 without the macro)
//   ir_if               instruction handshake and redirect (master side)
module instruction_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd_en,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [ADDR_W-1:0]         pc_out,
  output logic                      halted,
  instruction_fetch_unit_if.master  ir_if
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD0   = 3'd1,
    S_RD1   = 3'd2,
    S_RD2   = 3'd3,
    S_CAP   = 3'd4,
`ifdef FETCH_HALT_DETECT_EN
    S_VALID = 3'd5,
    S_HALT  = 3'd6
`else
    S_VALID = 3'd5
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] operand1_q, operand1_d;
  logic [DATA_W-1:0] operand2_q, operand2_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      opcode_q   <= '0;
      operand1_q <= '0;
      operand2_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      operand1_q <= operand1_d;
      operand2_q <= operand2_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    operand1_d = operand1_q;
    operand2_d = operand2_q;
    mem_addr   = '0;
    mem_rd_en  = 1'b0;

    // Each capture takes the byte requested one state earlier; address
    // arithmetic wraps naturally at ADDR_W bits.
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_RD0;
      end
      S_RD0: begin
        mem_addr  = pc_q;
        mem_rd_en = 1'b1;
        state_d   = S_RD1;
      end
      S_RD1: begin
        mem_addr  = pc_q + ADDR_W'(1);
        mem_rd_en = 1'b1;
        opcode_d  = mem_rdata;
        state_d   = S_RD2;
      end
      S_RD2: begin
        mem_addr   = pc_q + ADDR_W'(2);
        mem_rd_en  = 1'b1;
        operand1_d = mem_rdata;
        state_d    = S_CAP;
      end
      S_CAP: begin
        operand2_d = mem_rdata;
        state_d    = S_VALID;
      end
      S_VALID: begin
        if (ir_if.ir_ready) begin
          pc_d    = pc_q + ADDR_W'(3);
          state_d = en ? S_RD0 : S_IDLE;
`ifdef FETCH_HALT_DETECT_EN
          // A consumed halt opcode parks the sequencer with PC left on it.
          if (opcode_q == DATA_W'(8'hFF)) begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
`endif
        end
      end
`ifdef FETCH_HALT_DETECT_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything: the in-flight bytes are dropped (fields
    // keep their old value) and a coincident acceptance does not advance PC.
    if (ir_if.pc_load) begin
      pc_d       = ir_if.pc_load_addr;
      state_d    = en ? S_RD0 : S_IDLE;
      opcode_d   = opcode_q;
      operand1_d = operand1_q;
      operand2_d = operand2_q;
    end
  end

  assign ir_if.ir_opcode   = opcode_q;
  assign ir_if.ir_operand1 = operand1_q;
  assign ir_if.ir_operand2 = operand2_q;
  assign ir_if.ir_valid    = (state_q == S_VALID);
  assign pc_out            = pc_q;

`ifdef FETCH_HALT_DETECT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
